// File: rtl/div_seq_pkg.sv
// Shared types and constants for the iterative divide sequencer.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int          DIV_STEPS   = 32;
  localparam int          DIV_CNT_W   = $clog2(DIV_STEPS);
  localparam logic [31:0] DIV_INT_MIN = 32'h8000_0000;

  // Signed ops (DIV, REM) take operand signs into account.
  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  // Remainder ops return the remainder instead of the quotient.
  function automatic logic op_is_rem(input div_op_t op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract
// the divisor, keep the difference only when it does not go negative.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);

  // One guard bit above the remainder so the borrow is visible as a sign.
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;
  logic            fits;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign trial   = shifted - {2'b00, divisor_i};
  assign fits    = ~trial[XLEN+1];

  assign rem_o = fits ? trial[XLEN:0] : shifted[XLEN:0];
  assign quo_o = {quo_i[XLEN-2:0], fits};

endmodule

// File: rtl/div_seq.sv
// Iterative signed/unsigned divide/remainder sequencer for the execute stage.
// Magnitudes are divided by a 32-step restoring loop, signs are applied in FIX.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic [1:0]      op_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            flush_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] rslt_out,
  output logic            stall_out
);

  div_state_t             state_q;
  div_op_t                op_q;
  logic                   sign_a_q;
  logic                   sign_b_q;
  logic [XLEN:0]          rem_q;
  logic [XLEN-1:0]        quo_q;
  logic [XLEN-1:0]        dvsr_q;
  logic [DIV_CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]        rslt_q;
  logic                   done_q;

  logic [XLEN:0]          rem_d;
  logic [XLEN-1:0]        quo_d;

  div_op_t                op_sel;
  logic                   in_signed;
  logic                   sign_a;
  logic                   sign_b;
  logic [XLEN-1:0]        abs_a;
  logic [XLEN-1:0]        abs_b;
  logic                   div_zero;
  logic                   sgn_ovf;
  logic                   accept;
  logic [XLEN-1:0]        special_rslt;
  logic [XLEN-1:0]        quo_fix;
  logic [XLEN-1:0]        rem_fix;

  // Request decode: operand magnitudes and early-out detection.
  assign op_sel    = div_op_t'(op_in);
  assign in_signed = op_is_signed(op_sel);
  assign sign_a    = in_signed & a_in[XLEN-1];
  assign sign_b    = in_signed & b_in[XLEN-1];
  // INT_MIN negates to itself, which is the right unsigned magnitude.
  assign abs_a     = sign_a ? -a_in : a_in;
  assign abs_b     = sign_b ? -b_in : b_in;
  assign div_zero  = (b_in == '0);
  assign sgn_ovf   = in_signed & (a_in == XLEN'(DIV_INT_MIN)) & (b_in == '1);
  assign accept    = (state_q == IDLE) & start_in & ~flush_in;

  // Preloaded result for divide-by-zero and signed overflow.
  // NOTE: the default first assignment keeps this block free of inferred latches.
  always_comb begin
    special_rslt = '0;
    if (div_zero) begin
      special_rslt = op_is_rem(op_sel) ? a_in : '1;
    end else if (!op_is_rem(op_sel)) begin
      special_rslt = XLEN'(DIV_INT_MIN);
    end
  end

  // Sign correction applied once the magnitude loop has finished.
  assign quo_fix = ((op_q == DIV) && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
  assign rem_fix = ((op_q == REM) && sign_a_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvsr_q),
    .rem_o    (rem_d),
    .quo_o    (quo_d)
  );

  // Sequencer FSM with its datapath and output registers; flush wins over all.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= DIV;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      rslt_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_in) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start_in) begin
              op_q     <= op_sel;
              sign_a_q <= sign_a;
              sign_b_q <= sign_b;
              dvsr_q   <= abs_b;
              if (div_zero || sgn_ovf) begin
                rslt_q  <= special_rslt;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                rem_q   <= '0;
                quo_q   <= abs_a;
                cnt_q   <= DIV_CNT_W'(DIV_STEPS - 1);
                state_q <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - DIV_CNT_W'(1);
            if (cnt_q == '0) begin
              state_q <= FIX;
            end
          end
          FIX: begin
            rslt_q  <= op_is_rem(op_q) ? rem_fix : quo_fix;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy_out  = (state_q != IDLE);
  assign done_out  = done_q;
  assign rslt_out  = rslt_q;
  assign stall_out = (state_q == CALC) | (state_q == FIX) | accept;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed cases with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_div_seq;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_in = 1'b0;
  logic [1:0]  op_in = 2'b00;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        flush_in = 1'b0;
  logic        busy_out;
  logic        done_out;
  logic [31:0] rslt_out;
  logic        stall_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  div_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_in (start_in),
    .op_in    (op_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .flush_in (flush_in),
    .busy_out (busy_out),
    .done_out (done_out),
    .rslt_out (rslt_out),
    .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the operation rules.
  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == INT_MIN && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   return (a == INT_MIN && b == 32'hFFFF_FFFF) ? INT_MIN : 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return (a == INT_MIN && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Model: timer counts the busy cycles left; timer==1 is the DONE cycle.
  int          m_timer = 0;
  logic [31:0] m_val   = '0;
  logic [31:0] m_rslt  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_timer = 0;
      m_rslt  = '0;
    end else if (flush_in) begin
      m_timer = 0;
    end else if (m_timer > 0) begin
      m_timer--;
      if (m_timer == 1) m_rslt = m_val;
    end else if (start_in) begin
      m_val   = ref_div(op_in, a_in, b_in);
      m_timer = is_special(op_in, a_in, b_in) ? 1 : 34;
      if (m_timer == 1) m_rslt = m_val;
    end
  end

  always @(negedge clk) begin
    check("busy",  busy_out,  (m_timer != 0));
    check("done",  done_out,  (m_timer == 1));
    check("stall", stall_out, (m_timer >= 2) || (m_timer == 0 && start_in && !flush_in));
    check("rslt",  rslt_out,  m_rslt);
  end

  // Issue one request from IDLE and check its result and latency literally.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_val, input int exp_lat);
    int  n;
    bit  seen;
    @(posedge clk); #1;
    start_in = 1'b1; op_in = op; a_in = a; b_in = b;
    n = cyc;
    @(negedge clk);
    check({name, " stall@N"}, stall_out, 1'b1);
    @(posedge clk); #1;
    start_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_out) begin
        seen = 1;
        check(name, rslt_out, exp_val);
        check({name, " latency"}, cyc - n, exp_lat);
      end
    end
    if (!seen) check({name, " timeout"}, 32'd0, 32'd1);
    check({name, " model"}, ref_div(op, a, b), exp_val);
  endtask

  initial begin
    int n, dn, d1, d2;
    bit seen;

    #1 rst = 1'b1;
    @(negedge clk);
    check("reset busy",  busy_out,  1'b0);
    check("reset done",  done_out,  1'b0);
    check("reset rslt",  rslt_out,  32'h0);
    check("reset stall", stall_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 34);
    run_op("div -7/2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem -7/2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("rem 7/-2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);

    // Flush at N+10, new request accepted at N+11.
    @(posedge clk); #1;
    start_in = 1'b1; op_in = 2'b01; a_in = 32'd1000; b_in = 32'd3;
    n = cyc;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    start_in = 1'b1; op_in = 2'b01; a_in = 32'd9; b_in = 32'd3;
    @(negedge clk);
    check("flush busy", busy_out, 1'b0);
    check("flush rslt kept", rslt_out, 32'd1);
    @(posedge clk); #1;
    start_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done_out) begin
        seen = 1;
        check("post-flush divu 9/3", rslt_out, 32'd3);
        check("post-flush latency", cyc - n, 45);
      end
    end
    if (!seen) check("post-flush timeout", 32'd0, 32'd1);

    run_op("div 5/0",      2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu 5/0",     2'b11, 32'd5, 32'd0, 32'd5, 1);
    run_op("div min/-1",   2'b00, INT_MIN, 32'hFFFF_FFFF, INT_MIN, 1);
    run_op("rem min/-1",   2'b10, INT_MIN, 32'hFFFF_FFFF, 32'd0, 1);

    // start held high: one result per IDLE accept, no queuing.
    @(posedge clk); #1;
    start_in = 1'b1; op_in = 2'b01; a_in = 32'd50; b_in = 32'd5;
    n = cyc; dn = 0; d1 = 0; d2 = 0;
    for (int i = 0; i < 80 && dn < 2; i++) begin
      @(negedge clk);
      if (done_out) begin
        dn++;
        if (dn == 1) d1 = cyc - n;
        else d2 = cyc - n;
        check("held divu 50/5", rslt_out, 32'd10);
      end
    end
    @(posedge clk); #1;
    start_in = 1'b0;
    check("held done count", dn, 2);
    check("held first latency", d1, 34);
    check("held second latency", d2, 69);

    // Asynchronous reset mid-CALC.
    @(posedge clk); #1;
    start_in = 1'b1; op_in = 2'b00; a_in = 32'd12345; b_in = 32'd17;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst busy",  busy_out,  1'b0);
    check("async rst done",  done_out,  1'b0);
    check("async rst rslt",  rslt_out,  32'h0);
    check("async rst stall", stall_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    run_op("divu max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);

    // Randomized traffic checked by the per-cycle model compare.
    for (int i = 0; i < 3000; i++) begin
      int pick;
      @(posedge clk); #1;
      flush_in = ($urandom_range(0, 99) < 2);
      start_in = ($urandom_range(0, 99) < 40);
      op_in    = 2'($urandom_range(0, 3));
      pick     = $urandom_range(0, 9);
      case (pick)
        0: begin a_in = $urandom; b_in = 32'h0; end
        1: begin a_in = INT_MIN; b_in = 32'hFFFF_FFFF; end
        2, 3: begin
          a_in = $urandom_range(0, 300);
          b_in = $urandom_range(1, 20);
          if ($urandom_range(0, 1) == 1) a_in = -a_in;
          if ($urandom_range(0, 1) == 1) b_in = -b_in;
        end
        4: begin a_in = $urandom; b_in = $urandom_range(1, 15); end
        default: begin a_in = $urandom; b_in = $urandom >> $urandom_range(0, 31); end
      endcase
    end
    @(posedge clk); #1;
    start_in = 1'b0;
    flush_in = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/div_seq.md
# div_seq

Iterative divide sequencer for the execute stage. Accepts one signed or unsigned divide/remainder request at a time and runs a 32-step restoring division, one quotient bit per cycle. Holds the pipeline via `stall_out` until the result is ready, then presents it for one cycle. This replaces the single-cycle combinational divide/remainder path in execute. It has one requester, execute, and the pipeline `flush` can abort it.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `start_in` in 1: request; sampled only in IDLE.
- `op_in` in 2: operation select. 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a_in` in XLEN: dividend (rs1_dat); sampled with `start_in`.
- `b_in` in XLEN: divisor (rs2_dat); sampled with `start_in`.
- `flush_in` in 1: abort any operation; takes priority over `start_in`.
- `busy_out` out 1: high when state is not IDLE.
- `done_out` out 1: one-cycle pulse; `rslt_out` is valid in that cycle.
- `rslt_out` out XLEN: registered result; holds its value until the next DONE.
- `stall_out` out 1: asserted to upstream stages while a result is pending.

## Operation

States are IDLE, CALC, FIX and DONE.

- **IDLE**
  - If `start_in & ~flush_in`: latch `op_in`, the sign flags, `|a|` and `|b|` (signed ops only; 0x80000000 is kept as unsigned magnitude).
  - Special cases go straight to DONE with the result preloaded:
    - `b_in == 0`: quotient is 0xFFFFFFFF; remainder is `a_in`.
    - Signed overflow (`a_in == 0x80000000`, `b_in == 0xFFFFFFFF`, DIV/REM): quotient is 0x80000000; remainder is 0.
  - Otherwise: set remainder reg (33 b) = 0, quotient reg = `|a|`, count = 31, and go to CALC.
- **CALC** (32 cycles), each cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem − {1'b0, |b|}.
  - If trial is non-negative: rem = trial and quo[0] = 1; else quo[0] = 0.
  - Decrement count. After the count == 0 step, go to FIX.
- **FIX**
  - Quotient is negated if sign(a) ≠ sign(b) (DIV only).
  - Remainder is negated if sign(a) is set (REM only).
  - Select the quotient or remainder by op and load it into `rslt_out`. Go to DONE.
- **DONE**: `done_out` = 1, then go to IDLE. `start_in` is ignored in this state.

Other rules:
- `start_in` is ignored while busy; it does not queue.
- `flush_in` in any state: next state is IDLE. No `done_out` is produced and `rslt_out` is unchanged.
- Unsigned ops treat operands as raw 32-bit values with positive sign flags.
- `stall_out = (state == CALC) | (state == FIX) | (state == IDLE & start_in & ~flush_in)`.

## Timing

- Accept edge is the end of cycle N, when IDLE samples `start_in`.
- Normal path:
  - CALC occupies cycles N+1 … N+32.
  - FIX occupies cycle N+33.
  - DONE occupies cycle N+34, with `done_out` = 1 and `rslt_out` valid.
  - `stall_out` is high in cycles N … N+33 and low in N+34.
- Special cases (divide by zero, overflow): DONE occurs in cycle N+1 and `stall_out` is high only in cycle N.
- The earliest next accept is cycle N+35 (IDLE), or N+2 after a special case.
- `stall_out` has a combinational path from `start_in`/`flush_in`; all other outputs are registered.
- Reset values: state IDLE, `busy_out` 0, `done_out` 0, `rslt_out` 0, `stall_out` 0 (with `start_in` low). Internal regs are 0.
- Reset asserted mid-operation forces IDLE asynchronously and discards the operation; `done_out` is not produced.

## Structure

- Add to `lib/types.svh`:
  - `div_op_t` enum (DIV, DIVU, REM, REMU, 2 b).
  - `div_state_t` enum (IDLE, CALC, FIX, DONE).
  - Constants `DIV_STEPS` = 32 and `DIV_INT_MIN` = 32'h80000000.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: rem[32:0], quo[31:0], divisor[31:0].
  - Outputs: next rem and next quo.
  - Instantiated once; it can be unit-tested alone.
- The FSM, sign/fix logic, counter and output registers are in `div_seq`.

## Test plan

- DIVU a=100, b=7 accepted at cycle N → `done_out` at N+34 with `rslt_out` = 14; REMU with the same operands → 2. `stall_out` high N…N+33.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD (−3); REM with the same operands → 0xFFFFFFFF (−1). REM a=7, b=0xFFFFFFFE → 1.
- DIV 5/0 → 0xFFFFFFFF, and REMU 5/0 → 5, both with `done_out` at N+1. DIV 0x80000000/0xFFFFFFFF → 0x80000000, and REM with the same operands → 0, both at N+1.
- `flush_in` pulsed at N+10 → IDLE at N+11, no `done_out`, `rslt_out` keeps its prior value. A new DIVU 9/3 accepted at N+11 → 3 at N+45.
- `start_in` held high through busy and DONE → only one result. A second accept occurs first in IDLE (N+35) → second result at N+69.
- `rst` asserted asynchronously mid-CALC (cycle N+5, between edges) → all outputs 0 immediately. After release, DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
